// File: rtl/jpeg_bit_packer.sv
// Bit packer: concatenates right-aligned Huffman codes MSB-first into bytes with a valid/ready output.
// Optional JPEG 0xFF->0xFF,0x00 byte stuffing enabled by defining JPEG_BYTE_STUFF_EN.
module jpeg_bit_packer #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             code_valid_in,
    output logic             code_ready_out,
    input  logic [15:0]      code_in,
    input  logic [4:0]       code_len_in,
    input  logic             flush_in,
    output logic             byte_valid_out,
    input  logic             byte_ready_in,
    output logic [7:0]       byte_out,
    output logic [CNT_W-1:0] byte_count_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int BW = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_x;
    logic [ACC_W-1:0]  acc_next;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     cnt_x;
    logic [BW-1:0]     bit_cnt_next;
    logic [7:0]        byte_reg;
    logic [7:0]        byte_next;
    logic              byte_valid;
    logic              byte_valid_next;
    logic [CNT_W-1:0]  byte_count;

    logic              out_free;
    logic              accept;
    logic [4:0]        len;
    logic [15:0]       code_mask;
    logic [15:0]       masked;
    logic [BW:0]       shamt;
    logic              stuff_now;
    logic              stuff_next;

`ifdef JPEG_BYTE_STUFF_EN
    logic              stuff_pend;
    assign stuff_now = stuff_pend;
`else
    assign stuff_now = 1'b0;
`endif

    assign code_ready_out = (state == ST_RUN) && (bit_cnt <= BW'(ACC_W - 16));
    assign byte_valid_out = byte_valid;
    assign byte_out       = byte_reg;
    assign byte_count_out = byte_count;
    assign busy_out       = (state == ST_FLUSH);
    assign done_out       = (state == ST_DONE);

    always_comb begin
        out_free        = !byte_valid || byte_ready_in;
        accept          = code_valid_in && code_ready_out;
        len             = (code_len_in > 5'd16) ? 5'd16 : code_len_in;
        code_mask       = 16'hFFFF >> (5'd16 - len);
        masked          = code_in & code_mask;

        acc_x           = acc;
        cnt_x           = bit_cnt;
        byte_next       = byte_reg;
        byte_valid_next = byte_valid && !byte_ready_in;
        stuff_next      = stuff_now;

        if (out_free && stuff_now) begin
            byte_next       = 8'h00;
            byte_valid_next = 1'b1;
            stuff_next      = 1'b0;
        end else if (out_free && (bit_cnt >= BW'(8))) begin
            byte_next       = acc[ACC_W-1 -: 8];
            byte_valid_next = 1'b1;
            acc_x           = acc << 8;
            cnt_x           = bit_cnt - BW'(8);
`ifdef JPEG_BYTE_STUFF_EN
            stuff_next      = (acc[ACC_W-1 -: 8] == 8'hFF);
`endif
        end

        // New code lands directly below whatever survives this cycle's extraction.
        shamt        = (BW+1)'(ACC_W) - (BW+1)'(cnt_x) - (BW+1)'(len);
        acc_next     = acc_x;
        bit_cnt_next = cnt_x;
        if (accept) begin
            acc_next     = acc_x | (ACC_W'(masked) << shamt);
            bit_cnt_next = cnt_x + BW'(len);
        end

        // Padding is applied once the partial byte has reached the top of the
        // accumulator; the emitted stream is the same as padding it in place.
        if ((state == ST_FLUSH) && (cnt_x != '0) && (cnt_x < BW'(8))) begin
            acc_next     = acc_x | (({ACC_W{1'b1}} >> cnt_x) & ~({ACC_W{1'b1}} >> 8));
            bit_cnt_next = BW'(8);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (flush_in) state_next = ST_FLUSH;
            ST_FLUSH: if ((bit_cnt == '0) && !stuff_now && !byte_valid) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= ST_RUN;
        else           state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            acc        <= '0;
            bit_cnt    <= '0;
            byte_reg   <= '0;
            byte_valid <= 1'b0;
            byte_count <= '0;
        end else begin
            acc        <= acc_next;
            bit_cnt    <= bit_cnt_next;
            byte_reg   <= byte_next;
            byte_valid <= byte_valid_next;
            if (byte_valid && byte_ready_in) byte_count <= byte_count + 1'b1;
        end
    end

`ifdef JPEG_BYTE_STUFF_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) stuff_pend <= 1'b0;
        else           stuff_pend <= stuff_next;
    end
`else
    logic unused_stuff;
    assign unused_stuff = stuff_next;
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed self-checking bench for jpeg_bit_packer; expected bytes are hand-computed.
module tb_jpeg_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] code;
    logic [4:0]  code_len;
    logic        flush;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [15:0] byte_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    jpeg_bit_packer #(.ACC_W(32), .CNT_W(16)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .code_valid_in  (code_valid),
        .code_ready_out (code_ready),
        .code_in        (code),
        .code_len_in    (code_len),
        .flush_in       (flush),
        .byte_valid_out (byte_valid),
        .byte_ready_in  (byte_ready),
        .byte_out       (byte_data),
        .byte_count_out (byte_count),
        .busy_out       (busy),
        .done_out       (done)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a valid byte with ready high; the transfer happens on the following posedge.
    task automatic get_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        byte_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (byte_valid) begin
                b  = byte_data;
                ok = 1'b1;
                exp_count++;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; code_valid = 1'b0; code = '0; code_len = '0; flush = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (byte_valid !== 1'b0 || code_ready !== 1'b1 || byte_count !== 16'd0 || done !== 1'b0 ||
            busy !== 1'b0 || byte_data !== 8'h00) begin
            errors++;
            $display("FAIL reset got v=%b r=%b cnt=%0d d=%b b=%b byte=%h expected v=0 r=1 cnt=0 d=0 b=0 byte=00",
                     byte_valid, code_ready, byte_count, done, busy, byte_data);
        end
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_pack;
        @(negedge clk);
        byte_ready = 1'b1;
        code_valid = 1'b1; code = 16'h0005; code_len = 5'd3;
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL pack_ready got %b expected 1", code_ready); end
        @(negedge clk);
        code = 16'h001E; code_len = 5'd5;
        @(negedge clk);
        code_valid = 1'b0;
        checks++;
        if (byte_valid !== 1'b0) begin errors++; $display("FAIL pack_latency got valid=%b expected 0", byte_valid); end
        @(negedge clk);
        checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hBE) begin
            errors++; $display("FAIL pack_byte got v=%b byte=%h expected v=1 byte=be", byte_valid, byte_data);
        end
        if (byte_valid) exp_count++;
        @(negedge clk);
        checks++;
        if (byte_valid !== 1'b0 || byte_count !== 16'(exp_count) || exp_count != 1) begin
            errors++; $display("FAIL pack_count got v=%b cnt=%0d expected v=0 cnt=1", byte_valid, byte_count);
        end
    endtask

    task automatic test_stuff;
        logic [7:0] b;
        bit ok;
        bit extra;
        @(negedge clk);
        code_valid = 1'b1; code = 16'h00FF; code_len = 5'd8; byte_ready = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        get_byte(b, ok);
        checks++;
        if (!ok || b !== 8'hFF) begin errors++; $display("FAIL stuff_ff got ok=%b byte=%h expected ff", ok, b); end
`ifdef JPEG_BYTE_STUFF_EN
        get_byte(b, ok);
        checks++;
        if (!ok || b !== 8'h00) begin errors++; $display("FAIL stuff_zero got ok=%b byte=%h expected 00", ok, b); end
`endif
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (byte_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin errors++; $display("FAIL stuff_extra got extra byte=1 expected 0"); end
        checks++;
        if (byte_count !== 16'(exp_count)) begin
            errors++; $display("FAIL stuff_count got %0d expected %0d", byte_count, exp_count);
        end
    endtask

    task automatic test_boundary;
        logic [7:0] b;
        bit ok;
        logic [7:0] exp_b [4] = '{8'h34, 8'h5A, 8'hBE, 8'hEF};
        @(negedge clk);
        byte_ready = 1'b0;
        code_valid = 1'b1; code = 16'hFFFF; code_len = 5'd0;
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready0 got %b expected 1", code_ready); end
        @(negedge clk);
        code = 16'h1234; code_len = 5'd31;
        @(negedge clk);
        code_valid = 1'b0;
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready16a got %b expected 1", code_ready); end
        @(negedge clk);
        code_valid = 1'b1; code = 16'hF35A; code_len = 5'd8;
        @(negedge clk);
        checks++;
        if (code_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready16b got %b expected 1", code_ready); end
        code = 16'hBEEF; code_len = 5'd16;
        @(negedge clk);
        code_valid = 1'b0;
        checks++;
        if (code_ready !== 1'b0 || byte_valid !== 1'b1 || byte_data !== 8'h12) begin
            errors++; $display("FAIL bnd_full got r=%b v=%b byte=%h expected r=0 v=1 byte=12",
                               code_ready, byte_valid, byte_data);
        end
        byte_ready = 1'b1;
        if (byte_valid) exp_count++;
        for (int i = 0; i < 4; i++) begin
            get_byte(b, ok);
            checks++;
            if (!ok || b !== exp_b[i]) begin
                errors++; $display("FAIL bnd_byte%0d got ok=%b byte=%h expected %h", i, ok, b, exp_b[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (byte_count !== 16'(exp_count)) begin
            errors++; $display("FAIL bnd_count got %0d expected %0d", byte_count, exp_count);
        end
    endtask

    task automatic test_flush;
        logic [7:0] got;
        int nb;
        bit seen_done;
        bit busy_bad;
        @(negedge clk);
        byte_ready = 1'b1;
        code_valid = 1'b1; code = 16'h0002; code_len = 5'd3;
        @(negedge clk);
        code_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || code_ready !== 1'b0) begin
            errors++; $display("FAIL flush_busy got busy=%b ready=%b expected busy=1 ready=0", busy, code_ready);
        end
        nb = 0; got = '0; seen_done = 1'b0; busy_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin seen_done = 1'b1; break; end
            if (!busy) busy_bad = 1'b1;
            if (byte_valid) begin got = byte_data; nb++; exp_count++; end
        end
        checks++;
        if (nb != 1 || got !== 8'h5F) begin
            errors++; $display("FAIL flush_byte got n=%0d byte=%h expected n=1 byte=5f", nb, got);
        end
        checks++;
        if (!seen_done || busy_bad || busy !== 1'b0) begin
            errors++; $display("FAIL flush_done got done=%b busy_drop=%b busy=%b expected 1 0 0", seen_done, busy_bad, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || code_ready !== 1'b1 || byte_count !== 16'(exp_count)) begin
            errors++; $display("FAIL flush_run got d=%b b=%b r=%b cnt=%0d expected 0 0 1 %0d",
                               done, busy, code_ready, byte_count, exp_count);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL empty_flush got busy=%b done=%b expected 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || byte_valid !== 1'b0) begin
            errors++; $display("FAIL empty_done got done=%b v=%b expected 1 0", done, byte_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse got done=%b expected 0", done); end
    endtask

    task automatic test_back_to_back;
        int accepted;
        int nb;
        bit seq_bad;
        bit unstable;
        bit saw_not_ready;
        bit held_valid;
        bit extra;
        logic [7:0] held;
        accepted = 0; nb = 0; seq_bad = 1'b0; unstable = 1'b0; saw_not_ready = 1'b0;
        held_valid = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            byte_ready = (cyc >= 10);
            if (cyc < 10) begin
                if (byte_valid) begin
                    if (held_valid && byte_data !== held) unstable = 1'b1;
                    held = byte_data;
                    held_valid = 1'b1;
                end
                if (!code_ready) saw_not_ready = 1'b1;
            end
            if (byte_valid && byte_ready) begin
                if (byte_data !== ((nb % 2 == 0) ? 8'hA5 : 8'hC3)) seq_bad = 1'b1;
                nb++;
                exp_count++;
            end
            code_valid = (accepted < 4);
            code = 16'hA5C3; code_len = 5'd16;
            if (code_valid && code_ready) accepted++;
            if (nb == 8) break;
        end
        code_valid = 1'b0;
        checks++;
        if (nb != 8 || seq_bad) begin
            errors++; $display("FAIL b2b_seq got n=%0d order_bad=%b expected n=8 order_bad=0", nb, seq_bad);
        end
        checks++;
        if (unstable || !held_valid) begin
            errors++; $display("FAIL b2b_hold got unstable=%b held=%b expected 0 1", unstable, held_valid);
        end
        checks++;
        if (!saw_not_ready) begin errors++; $display("FAIL b2b_ready got drop=0 expected 1"); end
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (byte_valid) extra = 1'b1;
        end
        checks++;
        if (extra || byte_count !== 16'(exp_count)) begin
            errors++; $display("FAIL b2b_count got extra=%b cnt=%0d expected 0 %0d", extra, byte_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_flush;
        bit bad;
        @(negedge clk);
        byte_ready = 1'b0;
        code_valid = 1'b1; code = 16'h1234; code_len = 5'd16;
        @(negedge clk);
        code_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || byte_valid !== 1'b1) begin
            errors++; $display("FAIL rmf_pre got busy=%b v=%b expected 1 1", busy, byte_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_count = 0;
        checks++;
        if (byte_valid !== 1'b0 || byte_data !== 8'h00 || byte_count !== 16'd0 || busy !== 1'b0 ||
            done !== 1'b0 || code_ready !== 1'b1) begin
            errors++; $display("FAIL rmf_reset got v=%b byte=%h cnt=%0d b=%b d=%b r=%b expected 0 00 0 0 0 1",
                               byte_valid, byte_data, byte_count, busy, done, code_ready);
        end
        rst_n = 1'b1; byte_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || byte_valid || busy) bad = 1'b1;
        end
        checks++;
        if (bad || byte_count !== 16'd0) begin
            errors++; $display("FAIL rmf_quiet got activity=%b cnt=%0d expected 0 0", bad, byte_count);
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_stuff();
        test_boundary();
        test_flush();
        test_back_to_back();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
